// File: rtl/text_writer.sv
// Character-cell text buffer with cursor, backspace/return handling and a swept clear.
// Define TEXT_WRITER_SHADOW_EN to latch text_out once per frame instead of driving it live.
//
// state | meaning
// IDLE  | accepting characters, clear starts a sweep
// CLEAR | writing FILL into one cell per cycle, input stalled
module text_writer #(
  parameter int unsigned LEN  = 8,
  parameter logic [7:0]  FILL = 8'h20
) (
  input  logic             clk_0,
  input  logic             rst,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  output logic             char_ready,
  input  logic             clear,
  input  logic             frame_start,
  output logic [LEN*8-1:0] text_out,
  output logic [4:0]       cursor,
  output logic             busy
);

  localparam int unsigned IW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [4:0]    LEN_C  = 5'(LEN);
  localparam logic [IW-1:0] LAST_C = IW'(LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cells_q [LEN];
  logic [4:0]    cursor_q;
  logic [4:0]    cursor_m1;
  logic [IW-1:0] sweep_q;
  logic          sweep_last;
  logic          xfer;
  logic          printable;
  logic [LEN*8-1:0] work_flat;

  assign char_ready = rst && (state_q == IDLE) && !clear;
  assign xfer       = char_valid && char_ready;
  assign printable  = (char_in >= 8'h20) && (char_in <= 8'h7E);
  assign sweep_last = (sweep_q == LAST_C);
  assign cursor_m1  = cursor_q - 5'd1;
  assign busy       = (state_q == CLEAR);
  assign cursor     = cursor_q;

  always_ff @(posedge clk_0) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear) state_d = CLEAR;
      CLEAR:   if (sweep_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Clear wins over a same-cycle character because char_ready already masks xfer.
  always_ff @(posedge clk_0) begin
    if (!rst) begin
      for (int i = 0; i < LEN; i++) cells_q[i] <= FILL;
      cursor_q <= 5'd0;
      sweep_q  <= '0;
    end else if (state_q == CLEAR) begin
      cells_q[sweep_q] <= FILL;
      if (!sweep_last) sweep_q <= sweep_q + IW'(1);
    end else if (clear) begin
      cursor_q <= 5'd0;
      sweep_q  <= '0;
    end else if (xfer) begin
      if (printable) begin
        if (cursor_q < LEN_C) begin
          cells_q[cursor_q[IW-1:0]] <= char_in;
          cursor_q <= cursor_q + 5'd1;
        end
      end else if (char_in == 8'h08) begin
        if (cursor_q != 5'd0) begin
          cells_q[cursor_m1[IW-1:0]] <= FILL;
          cursor_q <= cursor_m1;
        end
      end else if (char_in == 8'h0D) begin
        cursor_q <= 5'd0;
      end
    end
  end

  for (genvar g = 0; g < LEN; g++) begin : g_pack
    assign work_flat[(LEN-g)*8-1 -: 8] = cells_q[g];
  end

`ifdef TEXT_WRITER_SHADOW_EN
  logic [LEN*8-1:0] shadow_q;

  // Commit samples the buffer before this edge's write, so that write shows next frame.
  always_ff @(posedge clk_0) begin
    if (!rst)                                  shadow_q <= {LEN{FILL}};
    else if (frame_start && state_q == IDLE)   shadow_q <= work_flat;
  end

  assign text_out = shadow_q;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign text_out = work_flat;
`endif

endmodule

// File: tb/tb_text_writer.sv
// Directed self-checking bench for text_writer (LEN=8, FILL=space); works with or without the shadow build.
module tb_text_writer;

`ifdef TEXT_WRITER_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif
  localparam logic [63:0] BLANK = {8{8'h20}};

  logic        clk_0 = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic        clear = 1'b0;
  logic        frame_start = 1'b0;
  logic [63:0] text_out;
  logic [4:0]  cursor;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int accepted = 0;

  text_writer #(.LEN(8), .FILL(8'h20)) dut (
    .clk_0(clk_0), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .clear(clear), .frame_start(frame_start),
    .text_out(text_out), .cursor(cursor), .busy(busy)
  );

  always #5 clk_0 = ~clk_0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_0);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    char_in = c;
    char_valid = 1'b1;
    if (char_valid && char_ready) accepted++;
    step();
    char_valid = 1'b0;
  endtask

  task automatic commit();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    n_cmp++;
    if (char_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_low: got %b expected 0", char_ready); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (text_out !== BLANK) begin n_bad++; $display("FAIL reset_text: got %h expected %h", text_out, BLANK); end
    n_cmp++;
    if (cursor !== 5'd0) begin n_bad++; $display("FAIL reset_cursor: got %0d expected 0", cursor); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++;
    if (char_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_release: got %b expected 1", char_ready); end
    step();
  endtask

  task automatic test_writes();
    logic [63:0] exp_pre;
    do_reset();
    send("P"); send("O"); send("N"); send("G");
    exp_pre = SHADOW ? BLANK : "PONG    ";
    n_cmp++;
    if (cursor !== 5'd4) begin n_bad++; $display("FAIL writes_cursor: got %0d expected 4", cursor); end
    n_cmp++;
    if (text_out !== exp_pre) begin n_bad++; $display("FAIL writes_pre_commit: got %h expected %h", text_out, exp_pre); end
    commit();
    n_cmp++;
    if (text_out !== "PONG    ") begin n_bad++; $display("FAIL writes_text: got %h expected %h", text_out, 64'h504F4E4720202020); end
  endtask

  task automatic test_overflow();
    logic [63:0] msg;
    do_reset();
    accepted = 0;
    msg = "ABCDEFGH";
    for (int i = 0; i < 10; i++) send(8'h41 + 8'(i));
    n_cmp++;
    if (accepted !== 10) begin n_bad++; $display("FAIL overflow_accepted: got %0d expected 10", accepted); end
    commit();
    n_cmp++;
    if (text_out !== msg) begin n_bad++; $display("FAIL overflow_text: got %h expected %h", text_out, msg); end
    n_cmp++;
    if (cursor !== 5'd8) begin n_bad++; $display("FAIL overflow_cursor: got %0d expected 8", cursor); end
  endtask

  task automatic test_backspace();
    do_reset();
    send("A"); send("B"); send(8'h08); send("C");
    commit();
    n_cmp++;
    if (text_out !== "AC      ") begin n_bad++; $display("FAIL bs_text: got %h expected %h", text_out, 64'h4143202020202020); end
    n_cmp++;
    if (cursor !== 5'd2) begin n_bad++; $display("FAIL bs_cursor: got %0d expected 2", cursor); end
    send(8'h0D);
    n_cmp++;
    if (cursor !== 5'd0) begin n_bad++; $display("FAIL return_cursor: got %0d expected 0", cursor); end
    send(8'h08);
    send(8'h07);
    commit();
    n_cmp++;
    if (cursor !== 5'd0) begin n_bad++; $display("FAIL bs_at_zero_cursor: got %0d expected 0", cursor); end
    n_cmp++;
    if (text_out !== "AC      ") begin n_bad++; $display("FAIL bs_at_zero_text: got %h expected %h", text_out, 64'h4143202020202020); end
    send("Z");
    commit();
    n_cmp++;
    if (text_out !== "ZC      ") begin n_bad++; $display("FAIL return_overwrite: got %h expected %h", text_out, 64'h5A43202020202020); end
  endtask

  task automatic test_clear();
    int ready_low;
    int busy_cnt;
    do_reset();
    send("H"); send("E"); send("L"); send("L"); send("O");
    commit();
    n_cmp++;
    if (text_out !== "HELLO   ") begin n_bad++; $display("FAIL clear_setup: got %h expected %h", text_out, 64'h48454C4C4F202020); end
    clear = 1'b1;
    char_valid = 1'b1;
    char_in = "X";
    #1;
    n_cmp++;
    if (char_ready !== 1'b0) begin n_bad++; $display("FAIL clear_priority_ready: got %b expected 0", char_ready); end
    step();
    clear = 1'b0;
    char_valid = 1'b0;
    n_cmp++;
    if (cursor !== 5'd0) begin n_bad++; $display("FAIL clear_cursor: got %0d expected 0", cursor); end
    ready_low = 0;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (!char_ready) ready_low++;
      if (busy) busy_cnt++;
      step();
    end
    n_cmp++;
    if (ready_low !== 8) begin n_bad++; $display("FAIL clear_ready_cycles: got %0d expected 8", ready_low); end
    n_cmp++;
    if (busy_cnt !== 8) begin n_bad++; $display("FAIL clear_busy_cycles: got %0d expected 8", busy_cnt); end
    commit();
    n_cmp++;
    if (text_out !== BLANK) begin n_bad++; $display("FAIL clear_text: got %h expected %h", text_out, BLANK); end
    n_cmp++;
    if (cursor !== 5'd0) begin n_bad++; $display("FAIL clear_cursor_end: got %0d expected 0", cursor); end
  endtask

  task automatic test_collisions();
    logic [63:0] exp_txt;
    do_reset();
    send("H"); send("I");
    commit();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    step();
    commit();
    exp_txt = SHADOW ? "HI      " : BLANK;
    n_cmp++;
    if (text_out !== exp_txt) begin n_bad++; $display("FAIL frame_in_clear_text: got %h expected %h", text_out, exp_txt); end
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL frame_in_clear_busy: got %b expected 1", busy); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL clear_not_restarted: got %b expected 0", busy); end
    send("A"); send("B");
    commit();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (char_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_low: got %b expected 0", char_ready); end
    step();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_sweep_busy: got %b expected 0", busy); end
    n_cmp++;
    if (text_out !== BLANK) begin n_bad++; $display("FAIL rst_sweep_text: got %h expected %h", text_out, BLANK); end
    n_cmp++;
    if (cursor !== 5'd0) begin n_bad++; $display("FAIL rst_sweep_cursor: got %0d expected 0", cursor); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (char_ready !== 1'b1) begin n_bad++; $display("FAIL rst_sweep_idle: got %b expected 1", char_ready); end
    step();
  endtask

  initial begin
    test_reset();
    test_writes();
    test_overflow();
    test_backspace();
    test_clear();
    test_collisions();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/text_writer.md
TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 SHALL have parameter LEN, default 8, meaning number of character cells (1..31).
REQ-002 SHALL have parameter FILL, default 8'h20, meaning the code written by reset and clear.
REQ-003 SHALL have port clk_0  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port char_in  input  8  ASCII code offered by the producer.
REQ-006 SHALL have port char_valid  input  1  char_in is valid this cycle.
REQ-007 SHALL have port char_ready  output  1  block accepts char_in this cycle.
REQ-008 SHALL have port clear  input  1  single-cycle request to blank the buffer.
REQ-009 SHALL have port frame_start  input  1  one-cycle pulse at start of vertical blanking.
REQ-010 SHALL have port text_out  output  LEN*8  packed string, cell 0 in bits [LEN*8-1 -: 8], MSB first.
REQ-011 SHALL have port cursor  output  5  next write cell, range 0..LEN.
REQ-012 SHALL have port busy  output  1  high while the clear sweep runs.

Function
REQ-013 SHALL hold a working buffer of LEN 8-bit cells plus a registered cursor.
REQ-014 SHALL implement FSM states IDLE and CLEAR; busy = (state==CLEAR).
REQ-015 SHALL drive char_ready = (state==IDLE) && !clear, combinationally.
REQ-016 SHALL treat a transfer as char_valid && char_ready at a clock edge; no other char_in is consumed.
REQ-017 SHALL, on a transfer of 8'h20..8'h7E with cursor<LEN, write the code to cell cursor and increment cursor, both at the same edge.
REQ-018 SHALL, on a printable transfer with cursor==LEN, accept and discard the code; cursor stays LEN.
REQ-019 SHALL, on transfer of 8'h08 (backspace) with cursor>0, decrement cursor and write FILL to the new cursor cell; with cursor==0, no change.
REQ-020 SHALL, on transfer of 8'h0D (return), set cursor to 0 without changing cells.
REQ-021 SHALL accept and discard every other code with no state change.
REQ-022 SHALL, on clear in IDLE, enter CLEAR and set cursor to 0; clear has priority over a same-cycle char_valid.
REQ-023 SHALL in CLEAR write FILL to one cell per cycle, cells 0..LEN-1 in order, then return to IDLE; char_ready is low for exactly LEN cycles after the clear edge.
REQ-024 SHALL ignore clear asserted while in CLEAR; the sweep is not restarted.
REQ-025 SHALL use a sweep index wide enough for LEN-1 and compare cursor to LEN at 5-bit width.

Reset
REQ-026 SHALL, with rst low at a clock edge, set all working cells and text_out cells to FILL, cursor=0, state IDLE, busy=0.
REQ-027 SHALL abort an in-progress CLEAR sweep or shadow commit on reset; reset takes priority over all inputs.
REQ-028 SHALL drive char_ready low while rst is low.

Configuration
REQ-029 SHALL recognise macro TEXT_WRITER_SHADOW_EN.
REQ-030 SHALL, with TEXT_WRITER_SHADOW_EN defined, register text_out and load it from the working buffer at the edge where frame_start is high and state is IDLE; a frame_start during CLEAR is skipped; a write at the same edge as the commit is not included (appears next frame).
REQ-031 SHALL, without TEXT_WRITER_SHADOW_EN, drive text_out combinationally from the working buffer (a write visible in the cycle after its transfer edge) and ignore frame_start.

Verification
REQ-032 SHALL test reset: rst low 2 cycles, LEN=8 -> text_out=64'h2020202020202020, cursor=0, char_ready=1 after release.
REQ-033 SHALL test writes: send "PONG" back-to-back then frame_start (shadow on) -> text_out=="PONG    ", cursor=4; no change before frame_start.
REQ-034 SHALL test overflow: send 10 printables "ABCDEFGHIJ" -> text_out=="ABCDEFGH", cursor=8, all 10 accepted.
REQ-035 SHALL test backspace: after "AB", send 8'h08 then 'C' -> "AC      ", cursor=2; 8'h08 at cursor 0 -> no change.
REQ-036 SHALL test clear: pulse clear with char_valid high on "HELLO" -> char_ready low 8 cycles, busy high 8 cycles, char not accepted, then "        ", cursor=0.
REQ-037 SHALL test collisions: frame_start during CLEAR -> text_out unchanged; rst low mid-sweep -> all FILL, IDLE next cycle.
